uart_tx_wb_slave: RTL and testbench
===================================

# uart_tx_wb_slave

Wishbone-style responder implementing the UART transmitter peripheral that the frequency-counter control unit programs and polls. It holds the baud, control, status and TX buffer registers at word addresses 0x3/0x4/0x5/0x7. On command it serialises one byte as an 8N1 frame on `tx_o`, using a 32-bit phase-accumulator baud generator, and raises a sticky done flag.

## Interface
- Parameters:
- `BAUD_RST`, 32'h0096_FEB5, reset value of the BAUD phase increment (115200 baud at 50 MHz).
- Ports:
- `clk_i` input 1: sole clock, rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `addr_i` input 32: register address, full 32-bit decode.
- `dat_i` input 32: write data.
- `dat_o` output 32: read data, registered.
- `we_i` input 1: 1 = write, 0 = read.
- `sel_i` input 4: byte-lane enables (used by BAUD and TXBUF only).
- `stb_i` input 1: transfer request.
- `cyc_i` input 1: not used in decode; transfers are qualified by `stb_i` alone.
- `ack_o` output 1: transfer acknowledge.
- `err_o`, `rty_o` output 1 each: tied 0.
- `tx_o` output 1: serial line, idles high.

## Operation
- Register map:
- 0x3 CTRL. Write with `dat_i[7]`=1 starts a frame if idle. A start while busy is ignored: no queue, DONE is not set. Read returns {24'b0, busy, 7'b0}.
- 0x4 BAUD. 32-bit phase increment, written per byte lane by `sel_i`. Read returns the full value.
- 0x5 STATUS. Read returns {26'b0, DONE at bit5, 4'b0, busy at bit0}. Any write clears DONE, regardless of data or `sel_i`.
- 0x7 TXBUF. 32-bit, written per byte lane by `sel_i`. A write with nonzero `sel_i` also sets LANE to the index of the lowest set `sel_i` bit. Read returns TXBUF.
- Unmapped addresses: reads return 0, writes are discarded, `ack_o` is still given.
- Frame transmission:
- On an accepted start, the shifter latches TXBUF[8*LANE +: 8] and the phase accumulator clears to 0.
- Frame order: start bit (0), data bits LSB first, stop bit (1), 10 bit periods total.
- Baud tick: each cycle while busy, ACC <= ACC + BAUD (32-bit). A tick is the carry-out of that add.
- Each bit is held until a tick, then the shifter advances to the next bit.
- The tick that ends the stop bit clears busy and sets DONE.
- States: IDLE → START → DATA (bit counter 0..7) → STOP → IDLE.
- BAUD = 0 produces no ticks; the transmitter stays busy until reset.
- BAUD written mid-frame takes effect on the next accumulate.

## Timing
- Bus handshake:
- `stb_i` is sampled on each rising edge. `ack_o` is high in the following cycle, for exactly one cycle per sampled request.
- Back-to-back requests are supported: `ack_o` stays high continuously, and there are no wait states.
- `dat_o` is registered in the same edge as `ack_o`. It holds the register value before any write in that cycle, and is 0 for writes.
- Write effects are visible from the cycle after `stb_i` is sampled.
- Transmit timing:
- `tx_o` goes low on the cycle after the start is accepted.
- With BAUD = 32'h1000_0000, each bit lasts exactly 16 cycles and a frame lasts 160 cycles.
- DONE and busy=0 are visible on the same edge that `tx_o` completes the stop bit.
- Simultaneous events:
- If a STATUS write (clear) coincides with DONE being set, set wins and DONE = 1.
- A CTRL start in the same cycle that a frame finishes is ignored, because the block is still busy that cycle.
- Reset values (all synchronous):
- `tx_o`=1, `ack_o`=0, `dat_o`=0.
- busy=0, DONE=0, LANE=0, TXBUF=0, ACC=0, BAUD=`BAUD_RST`.
- Reset mid-frame aborts the frame: `tx_o`=1 on the next edge and DONE is not set.

## Test plan
- Reset read-back: reset, then read 0x4, 0x5, 0x3 → `dat_o` = 0x0096FEB5, 0, 0; `ack_o` = 1 cycle after each `stb_i`; `tx_o` = 1.
- Single byte: BAUD=0x10000000, write TXBUF=0x000000A5 with sel 0001, start 0x80 → `tx_o` = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; STATUS reads 0x20 afterward.
- Byte lanes: write TXBUF=0x12345678 with sel 0100, start → transmitted byte 0x34. Then sel 1000, start → 0x12.
- Flag handling: after DONE, write 0x5 → STATUS=0. Issue a clear write on the exact DONE-set cycle → STATUS=0x20.
- Busy start: issue a second start mid-frame → frame is unchanged, exactly one DONE, and CTRL bit7 reads 1 while busy.
- Abort and unmapped: assert `rst_i` at cycle 50 of a frame → `tx_o`=1 next cycle and STATUS=0. Read 0x9 → 0 with `ack_o`. Write 0x9 → no register changes.

Source files
------------

// File: rtl/uart_tx_wb_slave.sv
// Wishbone-style register slave with an 8N1 UART transmitter.
// A 32-bit phase accumulator generates the baud tick from its carry-out.
module uart_tx_wb_slave #(
  parameter logic [31:0] BAUD_RST = 32'h0096_FEB5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        tx_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state;
  logic [31:0] baud;
  logic [31:0] txbuf;
  logic [31:0] acc;
  logic [1:0]  lane;
  logic        done;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;

  logic        busy;
  logic [32:0] acc_sum;
  logic        tick;
  logic        hit_ctrl, hit_baud, hit_status, hit_txbuf;
  logic        wr;
  logic        start_go;
  logic [1:0]  sel_lane;
  logic [31:0] rd_data;
  logic        unused_cyc;

  assign unused_cyc = cyc_i;
  assign err_o      = 1'b0;
  assign rty_o      = 1'b0;

  assign busy    = (state != S_IDLE);
  assign acc_sum = {1'b0, acc} + {1'b0, baud};
  assign tick    = acc_sum[32];

  assign hit_ctrl   = (addr_i == 32'h0000_0003);
  assign hit_baud   = (addr_i == 32'h0000_0004);
  assign hit_status = (addr_i == 32'h0000_0005);
  assign hit_txbuf  = (addr_i == 32'h0000_0007);
  assign wr         = stb_i & we_i;
  // A start while busy is dropped outright; there is no pending-start queue.
  assign start_go   = wr & hit_ctrl & dat_i[7] & ~busy;

  always_comb begin
    sel_lane = 2'd3;
    if (sel_i[0])      sel_lane = 2'd0;
    else if (sel_i[1]) sel_lane = 2'd1;
    else if (sel_i[2]) sel_lane = 2'd2;
  end

  always_comb begin
    rd_data = 32'h0;
    case (addr_i)
      32'h0000_0003: rd_data = {24'h0, busy, 7'h0};
      32'h0000_0004: rd_data = baud;
      32'h0000_0005: rd_data = {26'h0, done, 4'h0, busy};
      32'h0000_0007: rd_data = txbuf;
      default:       rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o   <= 1'b0;
      dat_o   <= 32'h0;
      tx_o    <= 1'b1;
      state   <= S_IDLE;
      baud    <= BAUD_RST;
      txbuf   <= 32'h0;
      acc     <= 32'h0;
      lane    <= 2'd0;
      done    <= 1'b0;
      shreg   <= 8'h0;
      bit_cnt <= 3'd0;
    end else begin
      ack_o <= stb_i;
      dat_o <= (stb_i && !we_i) ? rd_data : 32'h0;

      for (int i = 0; i < 4; i++) begin
        if (wr && hit_baud && sel_i[i])  baud[8*i +: 8]  <= dat_i[8*i +: 8];
        if (wr && hit_txbuf && sel_i[i]) txbuf[8*i +: 8] <= dat_i[8*i +: 8];
      end
      if (wr && hit_txbuf && (sel_i != 4'h0)) lane <= sel_lane;

      // Clear is placed before the FSM so a same-cycle DONE set wins.
      if (wr && hit_status) done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_go) begin
            state   <= S_START;
            tx_o    <= 1'b0;
            acc     <= 32'h0;
            shreg   <= txbuf[{lane, 3'b000} +: 8];
            bit_cnt <= 3'd0;
          end
        end
        S_START: begin
          acc <= acc_sum[31:0];
          if (tick) begin
            state <= S_DATA;
            tx_o  <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        S_DATA: begin
          acc <= acc_sum[31:0];
          if (tick) begin
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
              tx_o  <= 1'b1;
            end else begin
              tx_o    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        S_STOP: begin
          acc <= acc_sum[31:0];
          if (tick) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_wb_slave.sv
// Directed bench for uart_tx_wb_slave: register map, frame bit timing,
// byte lanes, DONE flag races, busy starts, reset abort and unmapped access.
module tb_uart_tx_wb_slave;

  localparam logic [31:0] BAUD_RST = 32'h0096_FEB5;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i, dat_i, dat_o;
  logic        we_i, stb_i, cyc_i;
  logic [3:0]  sel_i;
  logic        ack_o, err_o, rty_o, tx_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [0:0]  exp_q[$];
  logic [31:0] baud_m, txbuf_m;
  logic [1:0]  lane_m;

  uart_tx_wb_slave #(.BAUD_RST(BAUD_RST)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .addr_i(addr_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .we_i  (we_i),
    .sel_i (sel_i),
    .stb_i (stb_i),
    .cyc_i (cyc_i),
    .ack_o (ack_o),
    .err_o (err_o),
    .rty_o (rty_o),
    .tx_o  (tx_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Driver tasks: called at posedge+1, return at posedge+1 after the request edge.
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    addr_i = a; we_i = w; dat_i = d; sel_i = s; stb_i = 1'b1;
    @(posedge clk); #1;
    stb_i = 1'b0; we_i = 1'b0;
    chk("ack", {31'h0, ack_o}, 32'h1);
    rd = dat_o;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    bus(a, 1'b1, d, s, rd);
    chk("wr_dat_zero", rd, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus(a, 1'b0, 32'h0, 4'h0, rd);
    chk(tag, rd, exp);
  endtask

  task automatic wr_txbuf(input logic [31:0] d, input logic [3:0] s);
    wr(32'h7, d, s);
    for (int i = 0; i < 4; i++)
      if (s[i]) txbuf_m[8*i +: 8] = d[8*i +: 8];
    if (s[0])      lane_m = 2'd0;
    else if (s[1]) lane_m = 2'd1;
    else if (s[2]) lane_m = 2'd2;
    else if (s[3]) lane_m = 2'd3;
  endtask

  task automatic push_frame();
    logic [7:0] b;
    b = txbuf_m[{lane_m, 3'b000} +: 8];
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
  endtask

  // Scoreboard consumer: 10 bit periods x 16 cycles with BAUD = 0x10000000.
  // mode 0: STATUS read lands on the stop-bit end edge (busy still 1)
  // mode 1: STATUS clear lands on the DONE-set edge
  // mode 2: like mode 0, plus a second start and a CTRL read mid-frame
  task automatic run_frame(input int mode);
    logic [0:0] eb;
    int         k;
    int         hold;
    for (int b = 0; b < 10; b++) begin
      if (exp_q.size() == 0) eb = 1'b1;
      else eb = exp_q.pop_front();
      hold = 0;
      for (int c = 0; c < 16; c++) begin
        k = b * 16 + c;
        if (tx_o === eb) hold++;
        if (mode == 2 && k == 50) begin
          addr_i = 32'h3; we_i = 1'b1; dat_i = 32'h80; sel_i = 4'hf; stb_i = 1'b1;
        end
        if (mode == 2 && k == 51) begin
          stb_i = 1'b0; we_i = 1'b0;
          chk("busy_start_ack", {31'h0, ack_o}, 32'h1);
        end
        if (mode == 2 && k == 60) begin
          addr_i = 32'h3; we_i = 1'b0; stb_i = 1'b1;
        end
        if (mode == 2 && k == 61) begin
          stb_i = 1'b0;
          chk("ctrl_busy_read", dat_o, 32'h80);
        end
        if (k == 159) begin
          addr_i = 32'h5; we_i = (mode == 1); dat_i = 32'h0; sel_i = 4'h0; stb_i = 1'b1;
        end
        @(posedge clk); #1;
      end
      chk($sformatf("bit%0d_hold", b), hold, 16);
    end
    stb_i = 1'b0; we_i = 1'b0;
    chk("end_ack", {31'h0, ack_o}, 32'h1);
    if (mode != 1) chk("status_at_stop_end", dat_o, 32'h1);
    chk("line_idle", {31'h0, tx_o}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    rst_i = 1'b1; addr_i = 32'h0; dat_i = 32'h0; we_i = 1'b0;
    sel_i = 4'h0; stb_i = 1'b0; cyc_i = 1'b1;
    baud_m = BAUD_RST; txbuf_m = 32'h0; lane_m = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    chk("rst_tx", {31'h0, tx_o}, 32'h1);
    chk("rst_ack", {31'h0, ack_o}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    rd_chk("rst_baud", 32'h4, BAUD_RST);
    rd_chk("rst_status", 32'h5, 32'h0);
    rd_chk("rst_ctrl", 32'h3, 32'h0);

    // Back-to-back reads: ack stays high, no wait states
    addr_i = 32'h4; we_i = 1'b0; stb_i = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ack0", {31'h0, ack_o}, 32'h1);
    chk("b2b_dat0", dat_o, baud_m);
    addr_i = 32'h7;
    @(posedge clk); #1;
    stb_i = 1'b0;
    chk("b2b_ack1", {31'h0, ack_o}, 32'h1);
    chk("b2b_dat1", dat_o, txbuf_m);
    @(posedge clk); #1;
    chk("ack_drop", {31'h0, ack_o}, 32'h0);

    // BAUD byte-lane write, then full programming
    wr(32'h4, 32'hAABB_CCDD, 4'b0010);
    baud_m[15:8] = 8'hCC;
    rd_chk("baud_lane", 32'h4, baud_m);
    wr(32'h4, 32'h1000_0000, 4'hf);
    baud_m = 32'h1000_0000;
    rd_chk("baud_full", 32'h4, baud_m);

    // Single byte 0xA5 from lane 0
    wr_txbuf(32'h0000_00A5, 4'b0001);
    push_frame();
    wr(32'h3, 32'h80, 4'h1);
    run_frame(0);
    rd_chk("done_status", 32'h5, 32'h20);
    rd_chk("ctrl_idle", 32'h3, 32'h0);
    wr(32'h5, 32'h0, 4'h0);
    rd_chk("done_cleared", 32'h5, 32'h0);

    // Byte lanes 2 and 3
    wr_txbuf(32'h1234_5678, 4'b0100);
    rd_chk("txbuf_lane2", 32'h7, txbuf_m);
    push_frame();
    wr(32'h3, 32'h80, 4'h1);
    run_frame(0);
    wr(32'h5, 32'hFFFF_FFFF, 4'hf);
    wr_txbuf(32'h1234_5678, 4'b1000);
    push_frame();
    wr(32'h3, 32'h80, 4'h1);
    run_frame(1);
    rd_chk("clear_vs_set", 32'h5, 32'h20);

    // Second start while busy is ignored; exactly one DONE
    wr(32'h5, 32'h0, 4'h0);
    wr_txbuf(32'h0000_003C, 4'b0001);
    push_frame();
    wr(32'h3, 32'h80, 4'h1);
    run_frame(2);
    rd_chk("busy_start_done", 32'h5, 32'h20);
    wr(32'h5, 32'h0, 4'h0);
    repeat (200) @(posedge clk);
    #1;
    chk("no_second_frame_tx", {31'h0, tx_o}, 32'h1);
    rd_chk("no_second_done", 32'h5, 32'h0);

    // Reset mid-frame aborts
    wr_txbuf(32'h0000_0000, 4'b0001);
    wr(32'h3, 32'h80, 4'h1);
    repeat (50) @(posedge clk);
    #1;
    chk("abort_line_low", {31'h0, tx_o}, 32'h0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("abort_tx", {31'h0, tx_o}, 32'h1);
    baud_m = BAUD_RST; txbuf_m = 32'h0; lane_m = 2'd0;
    repeat (20) @(posedge clk);
    #1;
    rd_chk("abort_status", 32'h5, 32'h0);
    rd_chk("abort_baud", 32'h4, baud_m);

    // Unmapped accesses
    rd_chk("unmapped_read", 32'h9, 32'h0);
    wr(32'h9, 32'hFFFF_FFFF, 4'hf);
    wr(32'h103, 32'h80, 4'hf);
    wr(32'h104, 32'hFFFF_FFFF, 4'hf);
    @(posedge clk); #1;
    chk("unmapped_no_start", {31'h0, tx_o}, 32'h1);
    rd_chk("unmapped_baud", 32'h4, baud_m);
    rd_chk("unmapped_txbuf", 32'h7, txbuf_m);
    rd_chk("unmapped_status", 32'h5, 32'h0);
    rd_chk("unmapped_ctrl", 32'h3, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
